// File: rtl/imem_loader_if.sv
// Loader bus: UART byte strobe in, instruction RAM write port and CPU status out.
// The slave modport is the loader side; master is whoever drives bytes and watches the RAM port.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed UART bytes -> 32-bit words written to instruction RAM, then zero-fill and CPU release.
// Write pulse lands one cycle after each word's 4th byte; no backpressure, bytes accepted every cycle.
module imem_loader #(
  parameter int          ROM_SIZE  = 128,
  parameter logic [30:0] BASE_ADDR = 31'h0,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam int IW = $clog2(ROM_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d, chk_next;
  logic [15:0]   len_q, len_d, len_rx;
  logic [IW-1:0] idx_q, idx_d;
  logic [17:0]   bcnt_q, bcnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [23:0]   shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic          wr_en_q, wr_en_d;
  logic [30:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          all_in, to_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      csum_q    <= '0;
      shift_q   <= '0;
      to_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      csum_q    <= csum_d;
      shift_q   <= shift_d;
      to_q      <= to_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    csum_d    = csum_q;
    shift_d   = shift_q;
    to_d      = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_rx    = {len_q[15:8], bus.rx_data};
    all_in    = (bcnt_q == {len_q, 2'b00});
    to_active = 1'b0;

    if (bus.rx_data != csum_q)       chk_next = S_ERR;
    else if (len_q == 16'(ROM_SIZE)) chk_next = S_DONE;
    else                             chk_next = S_FILL;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.rx_valid && bus.rx_data == SYNC) begin
          state_d = S_LEN_HI;
          csum_d  = '0;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d   = {bus.rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d = len_rx;
          if (len_rx == 16'd0 || len_rx > 16'(ROM_SIZE)) state_d = S_ERR;
          else                                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wr_en_q) idx_d = idx_q + IW'(1);
        // all_in only holds in the last word's write cycle; a byte arriving then is already CHK
        if (all_in) begin
          state_d = bus.rx_valid ? chk_next : S_CHK;
        end else if (bus.rx_valid) begin
          shift_d = {shift_q[15:0], bus.rx_data};
          csum_d  = csum_q + bus.rx_data;
          bcnt_d  = bcnt_q + 18'd1;
          if (bcnt_q[1:0] == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + 31'({idx_q, 2'b00});
            wr_data_d = {shift_q, bus.rx_data};
          end
        end
      end
      S_CHK: begin
        if (bus.rx_valid) state_d = chk_next;
      end
      S_FILL: begin
        // exit one cycle after the last fill write so done never overlaps a write
        if (idx_q == IW'(ROM_SIZE)) begin
          state_d = S_DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + 31'({idx_q, 2'b00});
          wr_data_d = '0;
          idx_d     = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    to_active = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                (state_q == S_DATA)   || (state_q == S_CHK);
    if (to_active && !bus.rx_valid) begin
      if (to_q == TW'(TIMEOUT - 1)) state_d = S_ERR;
      else                          to_d    = to_q + TW'(1);
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.cpu_hold = (state_q != S_DONE);
  assign bus.err      = (state_q == S_ERR);
endmodule
